computron_core: RTL and testbench
=================================

Name: computron_core

Overview:
- Execution core of the 8-bit Computron CPU: control FSM, 8-bit ALU, 256x8 unified program/data memory, PC, two instruction registers (IR1, IR2) and an ALU output register.
- The 16x8 register file sits outside this block. The core drives its read/write addresses and write port, and consumes its combinational read data.
- Instructions are two bytes: IR1 = {opcode[7:4], r[3:0]}, IR2 = address/immediate or {ra[7:4], rb[3:0]}.

Parameters:
- MEM_INIT_FILE, "", hex file loaded into memory at time 0 via $readmemh; empty means memory starts undefined.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- resetN  input  1  asynchronous, active-low reset.
- rfAddr1  output  4  register-file read address 1.
- rfAddr2  output  4  register-file read address 2.
- rfAddr3  output  4  register-file write address.
- rfData1  input  8  register-file read data 1 (combinational).
- rfData2  input  8  register-file read data 2 (combinational).
- rfWriteData  output  8  register-file write data.
- rfWriteEnable  output  1  register-file write strobe; write occurs on the rising edge where it is high.
- progWrite  input  1  program-load write enable.
- progAddr  input  8  program-load address.
- progData  input  8  program-load data.
- pc  output  8  current program counter.
- zeroFlag  output  1  registered ALU zero flag.
- overflowFlag  output  1  registered ALU signed-overflow flag.
- halted  output  1  high while the FSM is in HALT.

Behaviour:
- Reset (resetN low, asynchronous):
  - PC, IR1, IR2, ALUOut, zeroFlag and overflowFlag all clear to 0.
  - halted = 0; FSM enters FETCH1.
  - Memory contents are not reset.
- Memory:
  - 256x8, asynchronous (combinational) read.
  - Synchronous write from either the STORE path or the load port.
  - progWrite has priority over STORE and is honoured regardless of resetN. Intended use is loading while resetN is low.
- ALU:
  - Operand1 = PC or rfData1; operand2 = 1 or rfData2.
  - Operations are add and sub; 8-bit result wraps modulo 256.
  - Result is registered into ALUOut.
  - Flags update only on ADD/SUB execution, never on PC increments:
    - zeroFlag = (result == 0).
    - overflowFlag = two's-complement signed overflow.
- FSM states and actions:
  - FETCH1: memory address = PC; IR1 <= mem[PC]; ALUOut <= PC+1.
  - INC1: PC <= ALUOut.
  - FETCH2: IR2 <= mem[PC]; ALUOut <= PC+1.
  - INC2: PC <= ALUOut. Next state EXEC.
  - EXEC, by opcode:
    - 0x0 NOP: no action. Next FETCH1.
    - 0x1 LOAD: memory address = IR2; rfWriteData = mem[IR2]; rfAddr3 = r; rfWriteEnable = 1. Next FETCH1.
    - 0x2 STORE: rfAddr1 = r; mem[IR2] <= rfData1. Next FETCH1.
    - 0x3 ADD: ALUOut <= R[ra] + R[rb]; flags update. Next WB.
    - 0x4 SUB: ALUOut <= R[ra] - R[rb]; flags update. Next WB.
    - 0x5 JMP: PC <= IR2. Next FETCH1.
    - 0x6 JZ: PC <= IR2 if zeroFlag, else no change. Next FETCH1.
    - 0x7 JV: PC <= IR2 if overflowFlag, else no change. Next FETCH1.
    - 0xF HALT: next HALT.
    - 0x8-0xE: treated as NOP.
  - WB: rfWriteData = ALUOut; rfAddr3 = r; rfWriteEnable = 1. Next FETCH1.
  - HALT: stays in HALT until reset; no PC, memory or register-file activity; halted = 1.
- Address outputs (combinational):
  - rfAddr1 = IR1[3:0] when the opcode is STORE, else IR2[7:4].
  - rfAddr2 = IR2[3:0].
  - rfAddr3 = IR1[3:0].
- rfWriteEnable is 0 in every state other than EXEC-LOAD and WB.
- Latency: ALU instructions take 6 cycles; all others take 5. Branches use the flags from the last ADD/SUB.
- PC wraps 0xFF -> 0x00. An instruction placed at 0xFF/0x00 fetches correctly.
- Reset asserted in any state aborts the instruction: no pending register write or memory write occurs afterwards.

Test Plan:
- Reset: hold resetN low, then release → pc=0x00, zeroFlag=0, overflowFlag=0, halted=0, rfWriteEnable=0; first fetch reads address 0x00.
- LOAD: mem[0]=0x11, mem[1]=0x80, mem[0x80]=0x2A → in cycle 5, rfWriteEnable=1, rfAddr3=1, rfWriteData=0x2A; afterwards pc=0x02.
- ADD with overflow: R2=0x70, R3=0x10, instruction 0x31,0x23 → WB writes 0x80 to R1, overflowFlag=1, zeroFlag=0. SUB with equal operands → result 0x00, zeroFlag=1, overflowFlag=0.
- STORE then HALT: STORE R4=0x5C to 0x90, then 0xF0 → mem[0x90]=0x5C; halted=1; pc frozen at 0x04 for 20+ cycles.
- Branches and wrap:
  - JZ with zeroFlag=1 → pc=IR2.
  - JZ with zeroFlag=0 → pc=+2.
  - JMP 0xFE, with NOP at 0xFE/0xFF → pc wraps to 0x00.
- Reset mid-ADD: assert resetN during EXEC of ADD → no WB write, pc=0x00, flags cleared.

Source files
------------

// File: rtl/computron_core.sv
// computron_core: execution core of the 8-bit Computron CPU
module computron_core #(
    parameter MEM_INIT_FILE = ""
) (
    input  logic       clock,
    input  logic       resetN,
    output logic [3:0] rfAddr1,
    output logic [3:0] rfAddr2,
    output logic [3:0] rfAddr3,
    input  logic [7:0] rfData1,
    input  logic [7:0] rfData2,
    output logic [7:0] rfWriteData,
    output logic       rfWriteEnable,
    input  logic       progWrite,
    input  logic [7:0] progAddr,
    input  logic [7:0] progData,
    output logic [7:0] pc,
    output logic       zeroFlag,
    output logic       overflowFlag,
    output logic       halted
);
    localparam logic [3:0] OP_LOAD = 4'h1, OP_STORE = 4'h2, OP_ADD = 4'h3, OP_SUB = 4'h4;
    localparam logic [3:0] OP_JMP = 4'h5, OP_JZ = 4'h6, OP_JV = 4'h7, OP_HALT = 4'hF;
    typedef enum logic [2:0] {S_FETCH1, S_INC1, S_FETCH2, S_INC2, S_EXEC, S_WB, S_HALT} state_t;
    state_t r_state, w_next;
    logic [7:0] r_mem [256];
    logic [7:0] r_pc, r_ir1, r_ir2, r_alu;
    logic       r_z, r_v;
    logic [3:0] w_op;
    logic       w_exec, w_alu_op, w_sub, w_store, w_ovf, w_branch;
    logic [7:0] w_a, w_b, w_res, w_maddr, w_mrd;
    assign w_op     = r_ir1[7:4];
    assign w_exec   = r_state == S_EXEC;
    assign w_alu_op = w_exec && (w_op == OP_ADD || w_op == OP_SUB);
    assign w_store  = w_exec && w_op == OP_STORE;
    assign w_branch = w_op == OP_JMP || (w_op == OP_JZ && r_z) || (w_op == OP_JV && r_v);
    assign w_sub   = w_exec && w_op == OP_SUB;
    assign w_a     = w_exec ? rfData1 : r_pc;
    assign w_b     = w_exec ? rfData2 : 8'd1;
    assign w_res   = w_sub ? w_a - w_b : w_a + w_b;
    assign w_ovf   = (w_a[7] ^ w_res[7]) & (w_sub ? (w_a[7] ^ w_b[7]) : ~(w_a[7] ^ w_b[7]));
    assign w_maddr = (r_state == S_FETCH1 || r_state == S_FETCH2) ? r_pc : r_ir2;
    assign w_mrd   = r_mem[w_maddr];
    always_ff @(posedge clock) begin
        if (progWrite)
            r_mem[progAddr] <= progData;
        else if (w_store)
            r_mem[r_ir2] <= rfData1;
    end
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN)
            r_state <= S_FETCH1;
        else
            r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH1: w_next = S_INC1;
            S_INC1:   w_next = S_FETCH2;
            S_FETCH2: w_next = S_INC2;
            S_INC2:   w_next = S_EXEC;
            S_EXEC:   w_next = w_alu_op ? S_WB : (w_op == OP_HALT ? S_HALT : S_FETCH1);
            S_WB:     w_next = S_FETCH1;
            default:  w_next = S_HALT;
        endcase
    end
    always_comb begin
        rfWriteEnable = (w_exec && w_op == OP_LOAD) || r_state == S_WB;
        rfWriteData   = r_state == S_WB ? r_alu : w_mrd;
        halted        = r_state == S_HALT;
        rfAddr1       = w_op == OP_STORE ? r_ir1[3:0] : r_ir2[7:4];
        rfAddr2       = r_ir2[3:0];
        rfAddr3       = r_ir1[3:0];
    end
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_pc  <= 8'd0;
            r_ir1 <= 8'd0;
            r_ir2 <= 8'd0;
            r_alu <= 8'd0;
            r_z   <= 1'b0;
            r_v   <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH1: begin
                    r_ir1 <= w_mrd;
                    r_alu <= w_res;
                end
                S_FETCH2: begin
                    r_ir2 <= w_mrd;
                    r_alu <= w_res;
                end
                S_INC1, S_INC2: r_pc <= r_alu;
                S_EXEC: begin
                    if (w_alu_op) begin
                        r_alu <= w_res;
                        r_z   <= w_res == 8'd0;
                        r_v   <= w_ovf;
                    end
                    if (w_branch)
                        r_pc <= r_ir2;
                end
                default: ;
            endcase
        end
    end
    assign pc           = r_pc;
    assign zeroFlag     = r_z;
    assign overflowFlag = r_v;
endmodule

// File: tb/tb_computron_core.sv
// tb_computron_core: directed program tests for computron_core with an external register-file model.
module tb_computron_core;
    logic       clock = 1'b0;
    logic       resetN, progWrite, rf_preset;
    logic [7:0] progAddr, progData;
    logic [3:0] rfAddr1, rfAddr2, rfAddr3;
    logic [7:0] rfData1, rfData2, rfWriteData, pc;
    logic       rfWriteEnable, zeroFlag, overflowFlag, halted;
    logic [7:0] rf [16];
    logic [15:0] wr_count, wr_saved;
    int n_vec = 0;
    int n_fail = 0;

    computron_core dut (
        .clock(clock), .resetN(resetN),
        .rfAddr1(rfAddr1), .rfAddr2(rfAddr2), .rfAddr3(rfAddr3),
        .rfData1(rfData1), .rfData2(rfData2),
        .rfWriteData(rfWriteData), .rfWriteEnable(rfWriteEnable),
        .progWrite(progWrite), .progAddr(progAddr), .progData(progData),
        .pc(pc), .zeroFlag(zeroFlag), .overflowFlag(overflowFlag), .halted(halted)
    );

    always #5 clock = ~clock;

    assign rfData1 = rf[rfAddr1];
    assign rfData2 = rf[rfAddr2];

    always @(posedge clock) begin
        if (rf_preset) begin
            for (int i = 0; i < 16; i++) rf[i] <= 8'h00;
            rf[2] <= 8'h70;
            rf[3] <= 8'h10;
            rf[4] <= 8'h5C;
            rf[6] <= 8'h33;
            rf[7] <= 8'h33;
            rf[8] <= 8'hFF;
            wr_count <= 16'd0;
        end else if (rfWriteEnable) begin
            rf[rfAddr3] <= rfWriteData;
            wr_count <= wr_count + 16'd1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] d);
        progWrite = 1'b1;
        progAddr  = a;
        progData  = d;
        tick(1);
        progWrite = 1'b0;
    endtask

    initial begin
        resetN = 1'b0; progWrite = 1'b0; progAddr = 8'h00; progData = 8'h00; rf_preset = 1'b1;
        tick(2);
        rf_preset = 1'b0;
        check("rst_pc", pc, 8'h00);
        check("rst_z", zeroFlag, 1'b0);
        check("rst_v", overflowFlag, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_we", rfWriteEnable, 1'b0);
        // LOAD R1 <- mem[0x80]
        load(8'h00, 8'h11); load(8'h01, 8'h80); load(8'h80, 8'h2A);
        resetN = 1'b1;
        check("fetch_pc0", pc, 8'h00);
        tick(4);
        check("load_we", rfWriteEnable, 1'b1);
        check("load_addr3", rfAddr3, 4'h1);
        check("load_wdata", rfWriteData, 8'h2A);
        tick(1);
        check("load_pc", pc, 8'h02);
        check("load_rf1", rf[1], 8'h2A);
        // ALU, branch and wrap program
        resetN = 1'b0;
        tick(1);
        load(8'h00, 8'h31); load(8'h01, 8'h23);
        load(8'h02, 8'h48); load(8'h03, 8'h67);
        load(8'h04, 8'h60); load(8'h05, 8'h20);
        load(8'h20, 8'h39); load(8'h21, 8'h23);
        load(8'h22, 8'h60); load(8'h23, 8'h50);
        load(8'h24, 8'h70); load(8'h25, 8'h40);
        load(8'h40, 8'h50); load(8'h41, 8'hFE);
        load(8'hFE, 8'h00); load(8'hFF, 8'h00);
        resetN = 1'b1;
        tick(4);
        check("add_exec_we", rfWriteEnable, 1'b0);
        tick(1);
        check("add_wb_we", rfWriteEnable, 1'b1);
        check("add_wb_addr3", rfAddr3, 4'h1);
        check("add_wb_data", rfWriteData, 8'h80);
        check("add_v", overflowFlag, 1'b1);
        check("add_z", zeroFlag, 1'b0);
        tick(1);
        check("add_pc", pc, 8'h02);
        check("add_rf1", rf[1], 8'h80);
        tick(6);
        check("sub_pc", pc, 8'h04);
        check("sub_z", zeroFlag, 1'b1);
        check("sub_v", overflowFlag, 1'b0);
        check("sub_rf8", rf[8], 8'h00);
        tick(5);
        check("jz_taken_pc", pc, 8'h20);
        tick(6);
        check("add2_pc", pc, 8'h22);
        check("add2_z", zeroFlag, 1'b0);
        check("add2_rf9", rf[9], 8'h80);
        tick(5);
        check("jz_not_taken_pc", pc, 8'h24);
        tick(5);
        check("jv_taken_pc", pc, 8'h40);
        tick(5);
        check("jmp_pc", pc, 8'hFE);
        tick(5);
        check("wrap_pc", pc, 8'h00);
        // Abort the ADD at 0x00 in EXEC
        tick(4);
        check("abort_pre_v", overflowFlag, 1'b1);
        wr_saved = wr_count;
        resetN = 1'b0;
        #1;
        check("abort_pc", pc, 8'h00);
        check("abort_z", zeroFlag, 1'b0);
        check("abort_v", overflowFlag, 1'b0);
        check("abort_we", rfWriteEnable, 1'b0);
        tick(2);
        check("abort_nowrite", wr_count, wr_saved);
        // STORE R4 -> 0x90 then HALT
        load(8'h00, 8'h24); load(8'h01, 8'h90); load(8'h02, 8'hF0); load(8'h03, 8'h00);
        resetN = 1'b1;
        tick(4);
        check("store_addr1", rfAddr1, 4'h4);
        tick(1);
        check("store_pc", pc, 8'h02);
        tick(5);
        check("halt_flag", halted, 1'b1);
        check("halt_pc", pc, 8'h04);
        tick(25);
        check("halt_pc_frozen", pc, 8'h04);
        check("halt_still", halted, 1'b1);
        check("halt_we", rfWriteEnable, 1'b0);
        resetN = 1'b0;
        #1;
        check("halt_reset", halted, 1'b0);
        // Read stored byte back: LOAD R5 <- mem[0x90]
        load(8'h00, 8'h15); load(8'h01, 8'h90);
        resetN = 1'b1;
        tick(4);
        check("readback_we", rfWriteEnable, 1'b1);
        check("readback_addr3", rfAddr3, 4'h5);
        check("readback_data", rfWriteData, 8'h5C);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
